// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: round-robin sharing of one pipelined BRAM read port among N_REQ requesters.
// Optional feature macro BRAM_ARB_STATS_EN adds saturating per-requester grant counters.
module bram_read_arbiter #(
    parameter int N_REQ       = 3,
    parameter int DATAWIDTH   = 8,
    parameter int DEPTH       = 16,
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 16,
    localparam int ADDRW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*ADDRW-1:0] req_addr,
    output logic [N_REQ-1:0]       gnt,
    output logic [DATAWIDTH-1:0]   rdata,
    output logic [N_REQ-1:0]       rvalid,
    output logic                   mem_read_en,
    output logic [ADDRW-1:0]       mem_read_addr,
    input  logic [DATAWIDTH-1:0]   mem_read_data,
    input  logic                   mem_read_dv
`ifdef BRAM_ARB_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [N_REQ*CNT_W-1:0] grant_count
`endif
);
    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDXW:0] N_REQ_W = (IDXW+1)'(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || MEM_LATENCY < 1 || MEM_LATENCY > 4 || CNT_W < 1) begin : g_param_check
        $error("bram_read_arbiter: parameter out of range");
    end

    logic [IDXW-1:0]  rr_ptr;
    logic [IDXW-1:0]  winner;
    logic [IDXW:0]    cand;
    logic             found;
    logic             any_req;
    logic             grant_ok;
    logic [ADDRW-1:0] sel_addr;
    logic [ADDRW-1:0] last_addr;

    assign any_req  = |req;
    assign grant_ok = any_req && !rst;

    // Stage 0: combinational round-robin search starting at rr_ptr, wrapping past N_REQ-1
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDXW+1)'(k);
            if (cand >= N_REQ_W) cand = cand - N_REQ_W;
            if (!found && req[cand[IDXW-1:0]]) begin
                winner = cand[IDXW-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = req_addr[ADDRW-1:0];
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == IDXW'(i)) sel_addr = req_addr[i*ADDRW +: ADDRW];
        end
    end

    assign gnt           = grant_ok ? (N_REQ'(1) << winner) : '0;
    assign mem_read_en   = grant_ok;
    assign mem_read_addr = any_req ? sel_addr : last_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (any_req) begin
            rr_ptr <= (winner == IDXW'(N_REQ - 1)) ? '0 : winner + IDXW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (grant_ok) last_addr <= sel_addr;
    end

    // Stages 1..MEM_LATENCY: owner-tag pipeline aligned with the BRAM read latency
    logic            tag_vld_p [MEM_LATENCY];
    logic [IDXW-1:0] tag_own_p [MEM_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < MEM_LATENCY; s++) tag_vld_p[s] <= 1'b0;
        end else begin
            tag_vld_p[0] <= any_req;
            for (int s = 1; s < MEM_LATENCY; s++) tag_vld_p[s] <= tag_vld_p[s-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_own_p[0] <= winner;
        for (int s = 1; s < MEM_LATENCY; s++) tag_own_p[s] <= tag_own_p[s-1];
    end

    assign rvalid = (tag_vld_p[MEM_LATENCY-1] && !rst) ? (N_REQ'(1) << tag_own_p[MEM_LATENCY-1]) : '0;
    assign rdata  = mem_read_data;

    // A BRAM whose data-valid disagrees with the tag pipeline means the latency parameter is wrong
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (mem_read_dv == tag_vld_p[MEM_LATENCY-1])
                else $error("bram_read_arbiter: mem_read_dv does not match in-flight tag");
        end
    end

`ifdef BRAM_ARB_STATS_EN
    logic [CNT_W-1:0] cnt [N_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst || stats_clr) begin
                cnt[i] <= '0;
            end else if (gnt[i] && cnt[i] != {CNT_W{1'b1}}) begin
                cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        assign grant_count[i*CNT_W +: CNT_W] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench for bram_read_arbiter: one MEM_LATENCY=1 and one MEM_LATENCY=2 instance on shared requests.
// Grant-counter checks are compiled in when BRAM_ARB_STATS_EN is defined.
module tb_bram_read_arbiter;
    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;

    logic [N-1:0]  gnt,  gnt2;
    logic [DW-1:0] rdata, rdata2;
    logic [N-1:0]  rvalid, rvalid2;
    logic          mem_read_en, mem_read_en2;
    logic [AW-1:0] mem_read_addr, mem_read_addr2;
    logic [DW-1:0] mem_read_data, mem_read_data2, d1;
    logic          mem_read_dv, mem_read_dv2, v1;
`ifdef BRAM_ARB_STATS_EN
    logic            stats_clr;
    logic [N*4-1:0]  grant_count;
    logic [N*16-1:0] grant_count2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bram_read_arbiter #(.N_REQ(N), .DATAWIDTH(DW), .DEPTH(16), .MEM_LATENCY(1), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt), .rdata(rdata),
        .rvalid(rvalid), .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data), .mem_read_dv(mem_read_dv)
`ifdef BRAM_ARB_STATS_EN
        , .stats_clr(stats_clr), .grant_count(grant_count)
`endif
    );

    bram_read_arbiter #(.N_REQ(N), .DATAWIDTH(DW), .DEPTH(16), .MEM_LATENCY(2), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt2), .rdata(rdata2),
        .rvalid(rvalid2), .mem_read_en(mem_read_en2), .mem_read_addr(mem_read_addr2),
        .mem_read_data(mem_read_data2), .mem_read_dv(mem_read_dv2)
`ifdef BRAM_ARB_STATS_EN
        , .stats_clr(stats_clr), .grant_count(grant_count2)
`endif
    );

    // BRAM contents: mem[i] = 8'hA0 + i
    logic [DW-1:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);

    always @(posedge clk) begin
        mem_read_data <= mem[mem_read_addr];
        mem_read_dv   <= rst ? 1'b0 : mem_read_en;
        d1             <= mem[mem_read_addr2];
        v1             <= rst ? 1'b0 : mem_read_en2;
        mem_read_data2 <= d1;
        mem_read_dv2   <= rst ? 1'b0 : v1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [N-1:0] exp_rr [6];

    initial begin
        exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100;
        exp_rr[3] = 3'b001; exp_rr[4] = 3'b010; exp_rr[5] = 3'b100;
        rst = 1'b1; req = '0; req_addr = '0;
`ifdef BRAM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        @(negedge clk);
        // Requests during reset must not be granted
        req = 3'b111;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_en", 32'(mem_read_en), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        @(negedge clk);
        rst = 1'b0; req = '0;
        #1;
        chk("post_rst_rvalid", 32'(rvalid), 32'h0);

        // 1: single request, addr 5
        @(negedge clk);
        req = 3'b001; req_addr[0*AW +: AW] = 4'd5;
        #1;
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_en", 32'(mem_read_en), 32'h1);
        chk("t1_addr", 32'(mem_read_addr), 32'h5);
        @(negedge clk);
        req = '0;
        #1;
        chk("t1_rvalid", 32'(rvalid), 32'h1);
        chk("t1_rdata", 32'(rdata), 32'hA5);
        chk("t1_lat2_early", 32'(rvalid2), 32'h0);
        @(negedge clk);
        #1;
        chk("t1_lat2_rvalid", 32'(rvalid2), 32'h1);
        chk("t1_lat2_rdata", 32'(rdata2), 32'hA5);

        // 5: grant to req1, then reset while its read is in flight
        @(negedge clk);
        req = 3'b010; req_addr[1*AW +: AW] = 4'd7;
        #1;
        chk("t5_gnt", 32'(gnt), 32'h2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_gnt", 32'(gnt), 32'h0);
        chk("t5_rst_rvalid", 32'(rvalid), 32'h0);
        @(negedge clk);
        rst = 1'b0; req = '0;
        #1;
        chk("t5_after_rvalid", 32'(rvalid), 32'h0);
        chk("t5_after_rvalid2", 32'(rvalid2), 32'h0);

        // 2: all requesters held, rr_ptr back at 0 after reset
        req_addr = {4'd14, 4'd9, 4'd2};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req = 3'b111;
            #1;
            chk($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(exp_rr[k]));
            if (k > 0) chk($sformatf("t2_rvalid%0d", k), 32'(rvalid), 32'(exp_rr[k-1]));
        end
        @(negedge clk);
        req = '0;
        #1;
        chk("t2_rvalid_last", 32'(rvalid), 32'h4);
        chk("t2_rdata_last", 32'(rdata), 32'hAE);

        // 3: requester 0 alone, back-to-back reads of addresses 0..3
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req = 3'b001; req_addr[0*AW +: AW] = AW'(k);
            #1;
            chk($sformatf("t3_gnt%0d", k), 32'(gnt), 32'h1);
            chk($sformatf("t3_addr%0d", k), 32'(mem_read_addr), 32'(k));
            if (k > 0) begin
                chk($sformatf("t3_rvalid%0d", k), 32'(rvalid), 32'h1);
                chk($sformatf("t3_rdata%0d", k), 32'(rdata), 32'hA0 + 32'(k - 1));
            end
        end
        @(negedge clk);
        req = '0;
        #1;
        chk("t3_rvalid_last", 32'(rvalid), 32'h1);
        chk("t3_rdata_last", 32'(rdata), 32'hA3);
        chk("t3_idle_en", 32'(mem_read_en), 32'h0);
        chk("t3_idle_addr_hold", 32'(mem_read_addr), 32'h3);

        // 4: requester 1 into the latency-2 instance
        @(negedge clk);
        req = 3'b010; req_addr[1*AW +: AW] = 4'd6;
        #1;
        chk("t4_gnt2", 32'(gnt2), 32'h2);
        @(negedge clk);
        req = '0;
        #1;
        chk("t4_rvalid2_t1", 32'(rvalid2), 32'h0);
        chk("t4_rvalid_lat1", 32'(rvalid), 32'h2);
        @(negedge clk);
        #1;
        chk("t4_rvalid2_t2", 32'(rvalid2), 32'h2);
        chk("t4_rdata2", 32'(rdata2), 32'hA6);
        chk("t4_rvalid_lat1_done", 32'(rvalid), 32'h0);

`ifdef BRAM_ARB_STATS_EN
        // 6: counts since reset are req0=6, req1=3, req2=2; then clear and saturate
        chk("t6_cnt1", 32'(grant_count[1*4 +: 4]), 32'd3);
        chk("t6_cnt2", 32'(grant_count[2*4 +: 4]), 32'd2);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        chk("t6_clr", 32'(grant_count), 32'h0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            req = 3'b001; req_addr[0*AW +: AW] = AW'(k);
        end
        @(negedge clk);
        req = '0;
        #1;
        chk("t6_sat0", 32'(grant_count[0*4 +: 4]), 32'd15);
        chk("t6_cnt1_zero", 32'(grant_count[1*4 +: 4]), 32'd0);
        chk("t6_wide_cnt0", 32'(grant_count2[0*16 +: 16]), 32'd20);
        @(negedge clk);
        stats_clr = 1'b1; req = 3'b001;
        @(negedge clk);
        stats_clr = 1'b0; req = '0;
        #1;
        chk("t6_clr_priority", 32'(grant_count[0*4 +: 4]), 32'd0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
